alu_issue_ctrl: RTL and testbench

Issue/collect front end for the 8-bit four-stage pipelined ALU. It accepts tagged operations on a valid/ready input port and drives the ALU's `op_code`/`A`/`B` from registers. It tracks every in-flight operation with a valid/tag pipe matched to the ALU latency, and returns `result` plus tag on a valid/ready output port. The ALU cannot stall, so the block uses credit-based admission into a result FIFO: no result is ever dropped under output backpressure.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_result_fifo.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 91 +++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit four-stage ALU and the blocks that feed it.
package alu_pkg;
  localparam int ALU_W       = 8;
  localparam int ALU_LATENCY = 4;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous show-ahead FIFO; head is forced to zero while empty so the
// outputs stay clean through reset without clearing the storage.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_idx, rd_idx;
  logic [CW-1:0]               count;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] i);
    return (i == AW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= nxt(wr_idx);
      if (do_pop)  rd_idx <= nxt(rd_idx);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect front end for the pipelined ALU: registered issue, valid/tag
// pipe matched to ALU latency, credit-guarded result FIFO.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int LATENCY    = ALU_LATENCY,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [ALU_W-1:0]   in_a,
  input  logic [ALU_W-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [2:0]         alu_op_code,
  output logic [ALU_W-1:0]   alu_a,
  output logic [ALU_W-1:0]   alu_b,
  input  logic [ALU_W-1:0]   alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALU_W-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [TAG_W-1:0] tag;
  } res_ent_t;

  logic                          accept, pop;
  logic [LATENCY:0]              vld_pipe;
  logic [LATENCY:0][TAG_W-1:0]   tag_pipe;
  logic [OCC_W-1:0]              occupancy;
  res_ent_t                      push_ent, head_ent;
  logic                          fifo_full, fifo_empty;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Credits are counted from registered state only, so a pop frees a slot next cycle.
  assign in_ready  = (occupancy < OCC_W'(FIFO_DEPTH)) & reset_n;
  assign busy      = (occupancy != '0);
  assign out_valid = ~fifo_empty;
  assign out_result = head_ent.result;
  assign out_tag    = head_ent.tag;
  assign push_ent   = '{result: alu_result, tag: tag_pipe[LATENCY]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op_code <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
    end else begin
      // Bubbles are issued as zeros; their results are never collected.
      alu_op_code <= accept ? in_op : 3'b000;
      alu_a       <= accept ? in_a  : {ALU_W{1'b0}};
      alu_b       <= accept ? in_b  : {ALU_W{1'b0}};
      vld_pipe    <= {vld_pipe[LATENCY-1:0], accept};
      tag_pipe    <= {tag_pipe[LATENCY-1:0], (accept ? in_tag : {TAG_W{1'b0}})};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          occupancy <= '0;
    else if (accept && !pop) occupancy <= occupancy + 1'b1;
    else if (!accept && pop) occupancy <= occupancy - 1'b1;
  end

  alu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ALU_W + TAG_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (vld_pipe[LATENCY]),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(vld_pipe[LATENCY] && fifo_full && !pop));
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 4-stage ALU and an in-order scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic          clk, reset_n;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]    in_op, alu_op_code;
  logic [7:0]    in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [TW-1:0] in_tag, out_tag;

  alu_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Behavioural ALU: result appears LAT edges after the registered inputs change.
  logic [LAT-1:0][7:0] alu_sr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alu_sr <= '0;
    else          alu_sr <= {alu_sr[LAT-2:0], alu_ref(alu_op_code, alu_a, alu_b)};
  end
  assign alu_result = alu_sr[LAT-1];

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int accepts = 0;

  typedef struct packed {
    logic [7:0]    res;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Scoreboard: push on accept, pop and compare on every consumer pop.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        sbq.push_back('{res: alu_ref(in_op, in_a, in_b), tag: in_tag});
        accepts++;
      end
      if (out_valid && out_ready) begin
        total++;
        pops++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_spurious got result=%h tag=%h, no result expected", out_result, out_tag);
        end else begin
          mon_e = sbq.pop_front();
          if ({out_result, out_tag} !== {mon_e.res, mon_e.tag}) begin
            bad++;
            $display("FAIL sb_order got result=%h tag=%h, expected result=%h tag=%h",
                     out_result, out_tag, mon_e.res, mon_e.tag);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if ({alu_op_code, alu_a, alu_b} !== 19'd0) begin bad++;
      $display("FAIL rst_alu got op=%h a=%h b=%h exp 0", alu_op_code, alu_a, alu_b); end
    total++; if ({out_result, out_tag} !== 12'd0) begin bad++;
      $display("FAIL rst_out got result=%h tag=%h exp 0", out_result, out_tag); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'b000; in_a = 8'h05; in_b = 8'h03; in_tag = 4'd1;
    tick();
    in_valid = 1'b0;
    total++; if ({alu_op_code, alu_a, alu_b} !== {3'b000, 8'h05, 8'h03}) begin bad++;
      $display("FAIL single_alu_regs got op=%h a=%h b=%h exp 0/05/03", alu_op_code, alu_a, alu_b); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early edge=%0d out_valid=%b exp=0", k, out_valid); end
      end
    end
    total++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h08, 4'd1}) begin bad++;
      $display("FAIL single_result got v=%b result=%h tag=%h exp v=1 result=08 tag=1", out_valid, out_result, out_tag); end
    tick();
    total++; if ({busy, out_valid} !== 2'b00) begin bad++;
      $display("FAIL single_drain got busy=%b out_valid=%b exp 0 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [5] = '{3'b001, 3'b000, 3'b110, 3'b111, 3'b101};
    logic [7:0] as  [5] = '{8'h03, 8'hFF, 8'h81, 8'h81, 8'h0F};
    logic [7:0] bs  [5] = '{8'h05, 8'h02, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp [5] = '{8'hFE, 8'h01, 8'h02, 8'h40, 8'hF0};
    int got = 0;
    int first = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = ops[i]; in_a = as[i]; in_b = bs[i]; in_tag = 4'(i + 2);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid) begin
        if (got == 0) first = c;
        total++;
        if ({out_result, out_tag} !== {exp[got], 4'(got + 2)} || c != first + got) begin
          bad++;
          $display("FAIL b2b_%0d got result=%h tag=%h cyc=%0d exp result=%h tag=%h cyc=%0d",
                   got, out_result, out_tag, c, exp[got], 4'(got + 2), first + got);
        end
        got++;
      end
      tick();
    end
    total++; if (got != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", got); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int target;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_op = 3'b000; in_a = 8'(sent); in_b = 8'h01; in_tag = 4'(sent);
      @(negedge clk);
      if (in_ready) sent++;
      tick();
    end
    total++; if (sent != 8) begin bad++; $display("FAIL bp_accepts got=%0d exp=8", sent); end
    total++; if ({in_ready, out_valid} !== 2'b01) begin bad++;
      $display("FAIL bp_full got in_ready=%b out_valid=%b exp 0 1", in_ready, out_valid); end
    target = pops + 9;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_same_cycle in_ready=%b exp=0", in_ready); end
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_refill in_ready=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && pops < target; c++) tick();
    total++; if (pops != target || busy !== 1'b0) begin bad++;
      $display("FAIL bp_drain got pops=%0d busy=%b exp pops=%0d busy=0", pops, busy, target); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 3'b100; in_a = 8'(8'h30 + i); in_b = 8'h0F; in_tag = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    total++; if ({out_valid, busy} !== 2'b11) begin bad++;
      $display("FAIL mid_pre got out_valid=%b busy=%b exp 1 1", out_valid, busy); end
    reset_n = 1'b0;
    #1;
    sbq.delete();
    total++; if ({in_ready, busy, out_valid, out_result, out_tag, alu_op_code, alu_a, alu_b} !== '0) begin bad++;
      $display("FAIL mid_async got rdy=%b busy=%b v=%b res=%h tag=%h op=%h a=%h b=%h exp all 0",
               in_ready, busy, out_valid, out_result, out_tag, alu_op_code, alu_a, alu_b); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    total++; if (seen != 0 || busy !== 1'b0) begin bad++;
      $display("FAIL mid_stale got out_valid_cycles=%0d busy=%b exp 0 0", seen, busy); end
  endtask

  task automatic test_random();
    int sent = 0;
    bit acc = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 30000 && sent < 2000; c++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(3) != 0) begin
          in_valid = 1'b1;
          in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && sbq.size() > 0; c++) tick();
    total++; if (sent != 2000) begin bad++; $display("FAIL rnd_sent got=%0d exp=2000", sent); end
    total++; if (sbq.size() != 0 || busy !== 1'b0) begin bad++;
      $display("FAIL rnd_drain got pending=%0d busy=%b exp 0 0", sbq.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
